// File: rtl/data_sram_pkg.sv
// Shared constants and types for the data SRAM responder.
// Optional access counters are enabled by DATA_SRAM_RESPONDER_ACCESS_CNT_EN.
package data_sram_pkg;

    // Value of addr[31:16] that selects the MMIO region by default.
    localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'hbfaf;

    // MMIO register byte offsets within the region (addr[15:0]).
    localparam logic [15:0] MMIO_LED_OFF     = 16'h0000;
    localparam logic [15:0] MMIO_SW_OFF      = 16'h0004;
    localparam logic [15:0] MMIO_TIMER_OFF   = 16'h0008;
    localparam logic [15:0] MMIO_SCRATCH_OFF = 16'h000C;
    localparam logic [15:0] MMIO_RDCNT_OFF   = 16'h0010;
    localparam logic [15:0] MMIO_WRCNT_OFF   = 16'h0014;

    // Which backing store an address lands in.
    typedef enum logic {
        SEL_RAM  = 1'b0,
        SEL_MMIO = 1'b1
    } region_sel_e;

    // Region decode from the upper address half.
    function automatic region_sel_e decode_region(input logic [15:0] addr_hi,
                                                  input logic [15:0] base_hi);
        return (addr_hi == base_hi) ? SEL_MMIO : SEL_RAM;
    endfunction

endpackage

// File: rtl/data_resp_mmio.sv
// MMIO register block: LED, switch sample, free-running TIMER, SCRATCH and,
// when DATA_SRAM_RESPONDER_ACCESS_CNT_EN is defined, RAM read/write counters.
// Reads are combinational on the current register values, so the caller's
// registered rdata sees the value held at the address edge (read-first).
module data_resp_mmio
    import data_sram_pkg::*;
#(
    parameter int LED_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,      // write strobe, already qualified by MMIO select
    input  logic [13:0]      word_off,   // addr[15:2]; byte lanes are ignored
    input  logic [31:0]      wdata,
`ifdef DATA_SRAM_RESPONDER_ACCESS_CNT_EN
    input  logic             ram_rd,     // this cycle is a RAM read
    input  logic             ram_wr,     // this cycle is a RAM write
`endif
    input  logic [LED_W-1:0] switch_in,
    output logic [LED_W-1:0] led_out,
    output logic [31:0]      rdata
);

    logic [15:0]      byte_off;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] sw_q;
    logic [31:0]      timer_q;
    logic [31:0]      scratch_q;
    logic             wr_led;
    logic             wr_timer;
    logic             wr_scratch;

    assign byte_off   = {word_off, 2'b00};
    assign wr_led     = wr_en && (byte_off == MMIO_LED_OFF);
    assign wr_timer   = wr_en && (byte_off == MMIO_TIMER_OFF);
    assign wr_scratch = wr_en && (byte_off == MMIO_SCRATCH_OFF);
    assign led_out    = led_q;

    // LED register: software writable, low LED_W bits of the write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       led_q <= '0;
        else if (wr_led) led_q <= wdata[LED_W-1:0];
    end

    // Switch sample: one register stage on the board inputs every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sw_q <= '0;
        else       sw_q <= switch_in;
    end

    // Timer: a write loads and takes priority over the increment; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         timer_q <= '0;
        else if (wr_timer) timer_q <= wdata;
        else               timer_q <= timer_q + 32'd1;
    end

    // Scratch register: plain 32-bit storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           scratch_q <= '0;
        else if (wr_scratch) scratch_q <= wdata;
    end

`ifdef DATA_SRAM_RESPONDER_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;
    logic        clr_rd;
    logic        clr_wr;

    assign clr_rd = wr_en && (byte_off == MMIO_RDCNT_OFF);
    assign clr_wr = wr_en && (byte_off == MMIO_WRCNT_OFF);

    // RAM read counter: a write to its offset clears it ahead of any increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rd_cnt_q <= '0;
        else if (clr_rd) rd_cnt_q <= '0;
        else if (ram_rd) rd_cnt_q <= rd_cnt_q + 32'd1;
    end

    // RAM write counter: same clear-over-increment priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       wr_cnt_q <= '0;
        else if (clr_wr) wr_cnt_q <= '0;
        else if (ram_wr) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
`endif

    // Read mux: unmapped offsets (and absent counters) return zero.
    always_comb begin
        rdata = '0;
        case (byte_off)
            MMIO_LED_OFF:     rdata = 32'(led_q);
            MMIO_SW_OFF:      rdata = 32'(sw_q);
            MMIO_TIMER_OFF:   rdata = timer_q;
            MMIO_SCRATCH_OFF: rdata = scratch_q;
`ifdef DATA_SRAM_RESPONDER_ACCESS_CNT_EN
            MMIO_RDCNT_OFF:   rdata = rd_cnt_q;
            MMIO_WRCNT_OFF:   rdata = wr_cnt_q;
`endif
            default:          rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder side of the CPU data SRAM bus: word RAM with synchronous read plus
// an MMIO window for board I/O. Optional RAM access counters are enabled by
// DATA_SRAM_RESPONDER_ACCESS_CNT_EN.
// Bus protocol: no valid/ready handshake. Every cycle is accepted; every cycle
// is a read, and sram_we=1 adds a full-word write. sram_rdata one cycle after
// an address edge carries the value held before that edge's write (read-first).
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int          RAM_AW       = 10,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT,
    parameter int          LED_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sram_we,
    input  logic [31:0]      sram_addr,
    input  logic [31:0]      sram_wdata,
    output logic [31:0]      sram_rdata,
    input  logic [LED_W-1:0] switch_in,
    output logic [LED_W-1:0] led_out
);

    region_sel_e       sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_we;
    logic              ram_we;
    logic [31:0]       mmio_rdata;
    logic [31:0]       mem [2**RAM_AW];

    // Byte lanes are not used: all accesses are full words.
    logic unused_byte_lanes;
    assign unused_byte_lanes = &{1'b0, sram_addr[1:0]};

    assign sel     = decode_region(sram_addr[31:16], MMIO_BASE_HI);
    assign ram_idx = sram_addr[RAM_AW+1:2];
    assign mmio_we = sram_we && (sel == SEL_MMIO);
    assign ram_we  = sram_we && (sel == SEL_RAM) && !reset;

    // RAM write port; contents are not reset and writes under reset are dropped.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= sram_wdata;
    end

    // Registered read data: RAM or MMIO value sampled at the address edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               sram_rdata <= '0;
        else if (sel == SEL_RAM) sram_rdata <= mem[ram_idx];
        else                     sram_rdata <= mmio_rdata;
    end

    data_resp_mmio #(
        .LED_W(LED_W)
    ) u_mmio (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (mmio_we),
        .word_off  (sram_addr[15:2]),
        .wdata     (sram_wdata),
`ifdef DATA_SRAM_RESPONDER_ACCESS_CNT_EN
        .ram_rd    (!sram_we && (sel == SEL_RAM)),
        .ram_wr    (sram_we && (sel == SEL_RAM)),
`endif
        .switch_in (switch_in),
        .led_out   (led_out),
        .rdata     (mmio_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, MMIO registers, timer wrap,
// asynchronous reset, and the optional access counters.
module tb_data_sram_responder;

    localparam logic [31:0] MMIO      = 32'hbfaf0000;
    localparam logic [31:0] A_LED     = MMIO + 32'h0;
    localparam logic [31:0] A_SW      = MMIO + 32'h4;
    localparam logic [31:0] A_TIMER   = MMIO + 32'h8;
    localparam logic [31:0] A_SCRATCH = MMIO + 32'hC;
    localparam logic [31:0] A_RDCNT   = MMIO + 32'h10;
    localparam logic [31:0] A_WRCNT   = MMIO + 32'h14;
    localparam logic [31:0] A_UNMAP   = MMIO + 32'h20;

    logic        clk;
    logic        reset;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    data_sram_responder dut (
        .clk        (clk),
        .reset      (reset),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .switch_in  (switch_in),
        .led_out    (led_out)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Drivers: present one bus cycle at a negedge, return at the next negedge.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        sram_we    = 1'b0;
    endtask

    // One bus cycle whose rdata (available after the edge) is scoreboarded.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
        exp_q.push_back(exp);
        drive(we, addr, wdata);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check(tag, sram_rdata, exp_q.pop_front());
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        switch_in  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rdata", sram_rdata, 32'h0);
        check("reset_led", 32'(led_out), 32'h0);
        reset = 1'b0;

        // RAM write then read, plus preloaded neighbour
        drive(1'b1, 32'h00000010, 32'h12345678);
        drive(1'b1, 32'h00000014, 32'h00000000);
        xfer("ram_rd_10", 1'b0, 32'h00000010, 32'h0, 32'h12345678);
        xfer("ram_rd_14", 1'b0, 32'h00000014, 32'h0, 32'h00000000);

        // Read-during-write is read-first
        drive(1'b1, 32'h00000020, 32'h11111111);
        xfer("rdw_old", 1'b1, 32'h00000020, 32'hAAAA5555, 32'h11111111);
        xfer("rdw_new", 1'b0, 32'h00000020, 32'h0, 32'hAAAA5555);

        // Byte lanes ignored and upper RAM address bits alias
        drive(1'b1, 32'h00000203, 32'h13579BDF);
        xfer("ram_lane", 1'b0, 32'h00000200, 32'h0, 32'h13579BDF);
        xfer("ram_alias", 1'b0, 32'h00001200, 32'h0, 32'h13579BDF);

        // LED: truncated on write, zero-extended on read
        drive(1'b1, A_LED, 32'hABCD00F0);
        check("led_out", 32'(led_out), 32'h000000F0);
        xfer("led_rd", 1'b0, A_LED, 32'h0, 32'h000000F0);

        // Switch sample, write ignored
        switch_in = 16'h0A5A;
        drive(1'b0, 32'h0, 32'h0);
        xfer("sw_rd", 1'b0, A_SW, 32'h0, 32'h00000A5A);
        drive(1'b1, A_SW, 32'hFFFFFFFF);
        xfer("sw_ro", 1'b0, A_SW, 32'h0, 32'h00000A5A);

        // Unmapped MMIO offset
        drive(1'b1, A_UNMAP, 32'h55AA55AA);
        xfer("unmapped", 1'b0, A_UNMAP, 32'h0, 32'h0);

        // Timer load and wrap
        drive(1'b1, A_TIMER, 32'hFFFFFFFE);
        xfer("timer_0", 1'b0, A_TIMER, 32'h0, 32'hFFFFFFFE);
        xfer("timer_1", 1'b0, A_TIMER, 32'h0, 32'hFFFFFFFF);
        xfer("timer_2", 1'b0, A_TIMER, 32'h0, 32'h00000000);

        // Asynchronous reset mid-run
        drive(1'b1, A_LED, 32'h00001234);
        drive(1'b1, A_SCRATCH, 32'hDEADBEEF);
        drive(1'b1, 32'h00000040, 32'h55555555);
        xfer("scratch_rd", 1'b0, A_SCRATCH, 32'h0, 32'hDEADBEEF);
        check("led_pre_rst", 32'(led_out), 32'h00001234);
        reset = 1'b1;
        #1;
        check("rst_async_led", 32'(led_out), 32'h0);
        check("rst_async_rdata", sram_rdata, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h00000040, 32'hCAFEF00D);
        drive(1'b1, A_SCRATCH, 32'h00000001);
        check("rst_hold_rdata", sram_rdata, 32'h0);
        reset = 1'b0;
        xfer("scratch_post", 1'b0, A_SCRATCH, 32'h0, 32'h0);
        xfer("ram_no_wr_rst", 1'b0, 32'h00000040, 32'h0, 32'h55555555);
        check("led_post", 32'(led_out), 32'h0);

`ifdef DATA_SRAM_RESPONDER_ACCESS_CNT_EN
        // Access counters
        drive(1'b1, A_RDCNT, 32'h0);
        drive(1'b1, A_WRCNT, 32'h0);
        drive(1'b1, 32'h00000100, 32'h00000001);
        drive(1'b1, 32'h00000104, 32'h00000002);
        drive(1'b1, 32'h00000108, 32'h00000003);
        xfer("cnt_ram0", 1'b0, 32'h00000100, 32'h0, 32'h00000001);
        xfer("cnt_ram1", 1'b0, 32'h00000104, 32'h0, 32'h00000002);
        xfer("cnt_ram2", 1'b0, 32'h00000108, 32'h0, 32'h00000003);
        xfer("cnt_ram3", 1'b0, 32'h00000100, 32'h0, 32'h00000001);
        xfer("cnt_ram4", 1'b0, 32'h00000104, 32'h0, 32'h00000002);
        xfer("wr_cnt", 1'b0, A_WRCNT, 32'h0, 32'd3);
        xfer("rd_cnt", 1'b0, A_RDCNT, 32'h0, 32'd5);
        drive(1'b0, 32'h00000100, 32'h0);
        xfer("rd_cnt_inc", 1'b0, A_RDCNT, 32'h0, 32'd6);
        drive(1'b1, A_WRCNT, 32'h12345678);
        xfer("wr_cnt_clr", 1'b0, A_WRCNT, 32'h0, 32'd0);
`else
        drive(1'b1, A_RDCNT, 32'h00000077);
        xfer("no_rd_cnt", 1'b0, A_RDCNT, 32'h0, 32'h0);
        xfer("no_wr_cnt", 1'b0, A_WRCNT, 32'h0, 32'h0);
`endif

        // Final report
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
